// File: rtl/lsu_redund_pkg.sv
// Shared definitions for the redundant LSU writeback checker.
// Holds the FSM state encoding, the fault_code values and the bit offsets
// of the writeback packet fields. Packet layout, MSB -> LSB:
//   wdat[XLEN] | itag[ITAG_W] | badaddr[ADDR_W] | err | ld | st | buserr
package lsu_redund_pkg;

  typedef enum logic [1:0] {
    ST_COLLECT = 2'd0,
    ST_CMP     = 2'd1,
    ST_OUT     = 2'd2,
    ST_FAULT   = 2'd3
  } state_t;

  localparam logic [1:0] FC_NONE     = 2'b00;
  localparam logic [1:0] FC_MISMATCH = 2'b01;
  localparam logic [1:0] FC_TIMEOUT  = 2'b10;

  // Fixed single-bit flag positions at the bottom of the packet
  localparam int OFF_BUSERR  = 0;
  localparam int OFF_ST      = 1;
  localparam int OFF_LD      = 2;
  localparam int OFF_ERR     = 3;
  localparam int OFF_BADADDR = 4;

  // Offsets of the width-dependent fields
  function automatic int off_itag(input int addr_w);
    return OFF_BADADDR + addr_w;
  endfunction

  function automatic int off_wdat(input int addr_w, input int itag_w);
    return off_itag(addr_w) + itag_w;
  endfunction

  function automatic int pkt_width(input int xlen, input int itag_w, input int addr_w);
    return off_wdat(addr_w, itag_w) + xlen;
  endfunction

endpackage

// File: rtl/lsu_redund_slot.sv
// Single-entry valid/ready capture register.
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset (clears full only)
//   en               slot may accept (controller is collecting)
//   in_valid/in_ready/in_pkt  upstream handshake
//   accept           handshake happening this cycle
//   clr              drop the held entry
//   full, pkt        held entry status and contents
module lsu_redund_slot #(
  parameter int PKT_W = 69
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [PKT_W-1:0] in_pkt,
  output logic             accept,
  input  logic             clr,
  output logic             full,
  output logic [PKT_W-1:0] pkt
);

  logic             full_q;
  logic [PKT_W-1:0] pkt_q;

  assign in_ready = en & ~full_q;
  assign accept   = in_valid & in_ready;
  assign full     = full_q;
  assign pkt      = pkt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q <= 1'b0;
    end else if (clr) begin
      full_q <= 1'b0;
    end else if (accept) begin
      full_q <= 1'b1;
    end
  end

  // Payload is qualified by full_q, so it carries no reset
  always_ff @(posedge clk) begin
    if (accept) begin
      pkt_q <= in_pkt;
    end
  end

endmodule

// File: rtl/lsu_redund_ctrl.sv
// Lockstep checker between main-core and shadow-core LSU writebacks.
// Each side is captured into its own slot; once both are held the packets
// are compared bitwise. A match is forwarded on the o_* handshake, a
// mismatch or an excessive main/shadow skew parks the block in FAULT until
// clr_fault.
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   m_valid/m_ready/m_pkt       main-core writeback in
//   s_valid/s_ready/s_pkt       shadow-core writeback in
//   o_valid/o_ready/o_pkt       checked writeback out
//   clr_fault                   pulse to leave FAULT
//   fault, fault_code           fault status (00 none, 01 mismatch, 10 timeout)
//   fault_cnt                   saturating count of FAULT entries
//   lsu_active                  busy hint for clock gating
module lsu_redund_ctrl
  import lsu_redund_pkg::*;
#(
  parameter  int XLEN    = 32,
  parameter  int ITAG_W  = 1,
  parameter  int ADDR_W  = 32,
  parameter  int TMO_CYC = 16,
  localparam int PKT_W   = pkt_width(XLEN, ITAG_W, ADDR_W)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             m_valid,
  output logic             m_ready,
  input  logic [PKT_W-1:0] m_pkt,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [PKT_W-1:0] s_pkt,
  output logic             o_valid,
  input  logic             o_ready,
  output logic [PKT_W-1:0] o_pkt,
  input  logic             clr_fault,
  output logic             fault,
  output logic [1:0]       fault_code,
  output logic [7:0]       fault_cnt,
  output logic             lsu_active
);

  localparam logic [7:0] TMO_L = 8'(TMO_CYC);

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  state_t           state, state_nxt;
  logic             a_full, b_full, a_hs, b_hs;
  logic [PKT_W-1:0] a_pkt, b_pkt;
  logic [7:0]       skew_cnt, skew_nxt;
  logic [1:0]       code_q, code_nxt;
  logic [7:0]       fcnt_q;
  logic             fault_entry;
  logic             collect, slot_clr;

  assign collect  = (state == ST_COLLECT);
  assign slot_clr = ((state == ST_OUT) & o_ready) | ((state == ST_FAULT) & clr_fault);

  lsu_redund_slot #(.PKT_W(PKT_W)) u_slot_a (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (collect),
    .in_valid (m_valid),
    .in_ready (m_ready),
    .in_pkt   (m_pkt),
    .accept   (a_hs),
    .clr      (slot_clr),
    .full     (a_full),
    .pkt      (a_pkt)
  );

  lsu_redund_slot #(.PKT_W(PKT_W)) u_slot_b (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (collect),
    .in_valid (s_valid),
    .in_ready (s_ready),
    .in_pkt   (s_pkt),
    .accept   (b_hs),
    .clr      (slot_clr),
    .full     (b_full),
    .pkt      (b_pkt)
  );

  // Next-state: a side counts as present if already held or captured on
  // this edge, which is what gives the two-cycle handshake-to-output latency.
  always_comb begin
    state_nxt   = state;
    skew_nxt    = '0;
    code_nxt    = code_q;
    fault_entry = 1'b0;
    case (state)
      ST_COLLECT: begin
        if ((a_full | a_hs) & (b_full | b_hs)) begin
          state_nxt = ST_CMP;
        end else if (a_full ^ b_full) begin
          skew_nxt = skew_cnt + 8'd1;
          if (skew_nxt == TMO_L) begin
            state_nxt   = ST_FAULT;
            code_nxt    = FC_TIMEOUT;
            skew_nxt    = '0;
            fault_entry = 1'b1;
          end
        end
      end
      ST_CMP: begin
        if (a_pkt == b_pkt) begin
          state_nxt = ST_OUT;
        end else begin
          state_nxt   = ST_FAULT;
          code_nxt    = FC_MISMATCH;
          fault_entry = 1'b1;
        end
      end
      ST_OUT: begin
        if (o_ready) begin
          state_nxt = ST_COLLECT;
        end
      end
      ST_FAULT: begin
        if (clr_fault) begin
          state_nxt = ST_COLLECT;
          code_nxt  = FC_NONE;
        end
      end
      default: state_nxt = ST_COLLECT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_COLLECT;
      skew_cnt <= '0;
      code_q   <= FC_NONE;
      fcnt_q   <= '0;
    end else begin
      state    <= state_nxt;
      skew_cnt <= skew_nxt;
      code_q   <= code_nxt;
      if (fault_entry) begin
        fcnt_q <= sat_inc8(fcnt_q);
      end
    end
  end

  // Outputs decode from state so an async reset drops o_valid at once;
  // o_pkt is gated because the slot payload itself is not reset.
  assign o_valid    = (state == ST_OUT);
  assign o_pkt      = o_valid ? a_pkt : '0;
  assign fault      = (state == ST_FAULT);
  assign fault_code = code_q;
  assign fault_cnt  = fcnt_q;
  assign lsu_active = a_full | b_full | m_valid | s_valid | ~collect;

endmodule

// File: tb/tb_lsu_redund_ctrl.sv
module tb_lsu_redund_ctrl;

  localparam int PKT_W = 69;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             m_valid, m_ready, s_valid, s_ready;
  logic [PKT_W-1:0] m_pkt, s_pkt, o_pkt;
  logic             o_valid, o_ready, clr_fault, fault, lsu_active;
  logic [1:0]       fault_code;
  logic [7:0]       fault_cnt;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  lsu_redund_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_pkt      (m_pkt),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_pkt      (s_pkt),
    .o_valid    (o_valid),
    .o_ready    (o_ready),
    .o_pkt      (o_pkt),
    .clr_fault  (clr_fault),
    .fault      (fault),
    .fault_code (fault_code),
    .fault_cnt  (fault_cnt),
    .lsu_active (lsu_active)
  );

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // {wdat, itag, badaddr, err, ld, st, buserr}
  function automatic logic [PKT_W-1:0] mk(input logic [31:0] wdat, input logic itag,
                                          input logic [31:0] ba, input logic [3:0] flags);
    return {wdat, itag, ba, flags};
  endfunction

  // wdat=32'h1234_5678 at bit 37, ld at bit 2
  localparam logic [PKT_W-1:0] P1 = 69'h2468ACF0000000004;

  logic [PKT_W-1:0] p2, p3;
  int               k;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    p2 = mk(32'hDEAD_BEEF, 1'b1, 32'h0000_1000, 4'b1010);
    p3 = mk(32'h0000_00A5, 1'b0, 32'hFFFF_FFF0, 4'b0001);
    rst_n = 1'b0; m_valid = 0; s_valid = 0; m_pkt = '0; s_pkt = '0;
    o_ready = 0; clr_fault = 0;
    #12;
    check("rst_o_valid", o_valid, 0);
    check("rst_o_pkt", o_pkt, 0);
    check("rst_fault", fault, 0);
    check("rst_code", fault_code, 0);
    check("rst_cnt", fault_cnt, 0);
    check("rst_active", lsu_active, 0);
    tick;
    rst_n = 1'b1;
    #1;
    check("post_rst_m_ready", m_ready, 1);
    check("post_rst_s_ready", s_ready, 1);

    // Both sides same cycle
    m_valid = 1; s_valid = 1; m_pkt = P1; s_pkt = P1; o_ready = 1;
    #1 check("same_active", lsu_active, 1);
    tick;
    m_valid = 0; s_valid = 0;
    check("same_n1_o_valid", o_valid, 0);
    check("same_n1_m_ready", m_ready, 0);
    tick;
    check("same_n2_o_valid", o_valid, 1);
    check("same_n2_o_pkt", o_pkt, P1);
    tick;
    check("same_n3_o_valid", o_valid, 0);
    check("same_n3_m_ready", m_ready, 1);
    check("same_n3_s_ready", s_ready, 1);

    // Shadow 5 cycles behind main
    m_valid = 1; m_pkt = p2;
    tick;
    m_valid = 0;
    check("skew_m_ready", m_ready, 0);
    check("skew_s_ready", s_ready, 1);
    repeat (3) tick;
    tick;
    s_valid = 1; s_pkt = p2;
    tick;
    s_valid = 0;
    check("skew_n6_o_valid", o_valid, 0);
    tick;
    check("skew_n7_o_valid", o_valid, 1);
    check("skew_n7_o_pkt", o_pkt, p2);
    check("skew_n7_fault", fault, 0);
    tick;

    // clr_fault outside FAULT has no effect
    clr_fault = 1;
    tick;
    clr_fault = 0;
    check("clr_idle_fault", fault, 0);
    check("clr_idle_cnt", fault_cnt, 0);
    check("clr_idle_m_ready", m_ready, 1);

    // Data mismatch in bit 0 of wdat
    m_valid = 1; s_valid = 1; m_pkt = p3; s_pkt = p3 ^ (69'd1 << 37);
    tick;
    m_valid = 0; s_valid = 0;
    tick;
    check("mis_fault", fault, 1);
    check("mis_code", fault_code, 2'b01);
    check("mis_cnt", fault_cnt, 1);
    check("mis_o_valid", o_valid, 0);
    check("mis_m_ready", m_ready, 0);
    check("mis_s_ready", s_ready, 0);
    for (int i = 0; i < 3; i++) begin
      tick;
      check("mis_hold_o_valid", o_valid, 0);
    end
    clr_fault = 1;
    tick;
    clr_fault = 0;
    check("mis_clr_fault", fault, 0);
    check("mis_clr_code", fault_code, 0);
    check("mis_clr_m_ready", m_ready, 1);
    check("mis_clr_s_ready", s_ready, 1);
    check("mis_clr_cnt", fault_cnt, 1);

    // Skew timeout: main only
    m_valid = 1; m_pkt = P1;
    tick;
    m_valid = 0;
    k = 0;
    while (!fault && k < 40) begin
      tick;
      k++;
    end
    check("tmo_cycles", k, 16);
    check("tmo_code", fault_code, 2'b10);
    check("tmo_cnt", fault_cnt, 2);
    clr_fault = 1;
    tick;
    clr_fault = 0;
    check("tmo_clr_fault", fault, 0);

    // Output backpressure
    m_valid = 1; s_valid = 1; m_pkt = p2; s_pkt = p2; o_ready = 0;
    tick;
    m_valid = 0; s_valid = 0;
    tick;
    for (int i = 0; i < 10; i++) begin
      m_valid = 1; m_pkt = p3;
      #1;
      check("bp_o_valid", o_valid, 1);
      check("bp_o_pkt", o_pkt, p2);
      check("bp_m_ready", m_ready, 0);
      tick;
    end
    m_valid = 0; o_ready = 1;
    #1 check("bp_release_o_valid", o_valid, 1);
    tick;
    check("bp_after_active", lsu_active, 0);
    check("bp_after_m_ready", m_ready, 1);

    // Async reset while in OUT
    m_valid = 1; s_valid = 1; m_pkt = P1; s_pkt = P1; o_ready = 0;
    tick;
    m_valid = 0; s_valid = 0;
    tick;
    check("rst_out_pre_o_valid", o_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_out_o_valid", o_valid, 0);
    check("rst_out_o_pkt", o_pkt, 0);
    check("rst_out_cnt", fault_cnt, 0);
    tick;
    rst_n = 1'b1; o_ready = 1;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("rst_out_stale_o_valid", o_valid, 0);
      check("rst_out_stale_active", lsu_active, 0);
      tick;
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
